eth_pcs_tx_gearbox: RTL and testbench
=====================================

Name: eth_pcs_tx_gearbox

Overview:
Transmit-side 66b->64b gearbox of the 10GBASE-R PCS, placed between the 64b/66b encoder/scrambler and the 64-bit PMA/SERDES interface. It packs 66-bit blocks (2-bit sync header plus 64-bit scrambled payload) into a continuous 64-bit word stream. It backpressures the encoder for one cycle every 32 blocks. The RX block-sync logic at the far end locks onto the sync headers this block places in the stream.

Parameters:
W_DATA, 64, payload and output word width (fixed; other values unsupported)
W_SYNC, 2, sync header width (fixed)
N_BLK, W_DATA/W_SYNC = 32, blocks per gearbox frame; one pause cycle follows each frame

Ports:
i_clk  in  1  clock
i_reset  in  1  reset
i_sync_hdr  in  W_SYNC  sync header of the block (SYNC_CTRL or SYNC_DATA; passed through unchecked)
i_data  in  W_DATA  scrambled block payload
i_valid  in  1  block present on i_sync_hdr/i_data
o_ready  out  1  gearbox accepts a block this cycle
o_data  out  W_DATA  output word; bit 0 is transmitted first
o_valid  out  1  o_data holds a valid word

Behaviour:
- Reset: i_reset is synchronous and active-high; the clock is i_clk. Reset clears seq to 0, residual to 0, o_data to 0 and o_valid to 0. o_ready is 0 while i_reset is high.
- Block bit order: blk[65:0] = {i_data, i_sync_hdr}. blk[0] = i_sync_hdr[0] goes on the wire first, and the header always precedes its payload.
- State:
  - seq: 6-bit counter, range 0..N_BLK.
  - residual: up to 64-bit register holding 2*seq unsent bits in its low bits.
- o_ready = (seq != N_BLK) and not i_reset. It is combinational from registered state only, with no dependence on i_valid.
- Accept = i_valid and o_ready. On accept with seq = k (0..31):
  - Form w = {blk, residual[2k-1:0]}, width 66+2k.
  - Next o_data = w[63:0] and next o_valid = 1.
  - residual <= w[65+2k:64] (2k+2 bits).
  - seq <= k+1.
- Pause cycle (seq = N_BLK): residual holds exactly 64 bits.
  - Next o_data = residual and next o_valid = 1.
  - residual <= 0 and seq <= 0.
  - i_valid is ignored and no block is accepted.
- Idle cycle (seq < N_BLK and i_valid = 0): seq and residual hold, next o_valid = 0, and o_data holds its previous value.
  - The encoder normally streams continuously. Gaps are legal and cause no data loss and no extra or duplicate bits.
- Latency: o_data and o_valid are registered, one cycle after the accept or pause cycle.
- Throughput: 32 blocks in, 33 words out, over 33 cycles with continuous input. This is a 2112-bit frame with no padding bits.
- i_valid high during the pause cycle: the block is not consumed. Upstream must hold it until o_ready is high.
- Reset mid-frame: partial residual bits are discarded. The first accepted block after reset starts at o_data[0].
- Wrap: seq moves from N_BLK to 0 only via the pause cycle. seq never exceeds N_BLK.

Test Plan:
1. Reset -> o_valid = 0, o_data = 0, o_ready = 0 during reset and 1 on the first cycle after. Then one block, sync = 2'b01 and data = 64'hFFFF_FFFF_FFFF_FFFF -> next cycle o_valid = 1, o_data = 64'hFFFF_FFFF_FFFF_FFFD. Residual is 2'b11, which appears in o_data[1:0] of the next word.
2. 32 consecutive blocks with data = block index and sync alternating 01/10 -> o_ready low on the 33rd cycle only. Exactly 33 valid words result. Their concatenation, word 0 first, LSB first, equals the 32 blocks' {data, sync} concatenation bit-exactly.
3. Continuous random stream for 1000 frames -> o_ready low exactly once every 33 cycles and o_valid never drops. The checker model reassembles 66-bit blocks with zero mismatches.
4. i_valid deasserted for 3 cycles after block 5 -> o_valid = 0 for those 3 cycles, seq stays 5. The resumed stream is identical to the gap-free stream apart from timing.
5. i_valid held high through the pause cycle with block X -> X is not accepted then, and is accepted on the next cycle. The output stream contains X exactly once.
6. i_reset pulsed after block 17 -> o_valid = 0 and seq = 0 after reset. The next block appears at o_data[1:0] = its sync header, and the pause occurs after 32 further blocks.

Source files
------------

// File: rtl/eth_pcs_tx_gearbox.sv
// 10GBASE-R transmit 66b->64b gearbox: packs {payload, sync header} blocks LSB-first into a
// continuous 64-bit word stream, pausing the encoder for one cycle after every 32 blocks.
module eth_pcs_tx_gearbox #(
  parameter int unsigned W_DATA = 64,
  parameter int unsigned W_SYNC = 2
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic [W_SYNC-1:0] i_sync_hdr,
  input  logic [W_DATA-1:0] i_data,
  input  logic              i_valid,
  output logic              o_ready,
  output logic [W_DATA-1:0] o_data,
  output logic              o_valid
);

  localparam int unsigned N_BLK  = W_DATA / W_SYNC;
  localparam int unsigned W_BLK  = W_DATA + W_SYNC;
  localparam int unsigned W_PACK = 2 * W_DATA;
  localparam int unsigned W_SEQ  = $clog2(N_BLK + 1);
  localparam int unsigned W_SH   = $clog2(W_PACK);
  localparam logic [W_SEQ-1:0] SeqLast = W_SEQ'(N_BLK);

  logic [W_SEQ-1:0]  seq_q, seq_d;
  logic [W_DATA-1:0] residual_q, residual_d;
  logic [W_DATA-1:0] data_q, data_d;
  logic              valid_q, valid_d;

  logic [W_BLK-1:0]  blk;
  logic [W_SH-1:0]   shamt;
  logic [W_PACK-1:0] packed_w;
  logic              pause;

  assign blk   = {i_data, i_sync_hdr};
  assign pause = (seq_q == SeqLast);
  assign shamt = W_SH'(32'(seq_q) * W_SYNC);

  // Residual bits above 2*seq are always zero, so a plain OR merges them under the new block.
  assign packed_w = (W_PACK'(blk) << shamt) | W_PACK'(residual_q);

  assign o_ready = !pause && !i_reset;
  assign o_data  = data_q;
  assign o_valid = valid_q;

  always_comb begin
    seq_d      = seq_q;
    residual_d = residual_q;
    data_d     = data_q;
    valid_d    = 1'b0;
    if (pause) begin
      data_d     = residual_q;
      valid_d    = 1'b1;
      residual_d = '0;
      seq_d      = '0;
    end else if (i_valid) begin
      data_d     = packed_w[W_DATA-1:0];
      valid_d    = 1'b1;
      residual_d = packed_w[W_PACK-1:W_DATA];
      seq_d      = seq_q + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      seq_q      <= '0;
      residual_q <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
    end else begin
      seq_q      <= seq_d;
      residual_q <= residual_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
    end
  end

  a_seq_range : assert property (@(posedge i_clk) disable iff (i_reset) seq_q <= SeqLast);
  a_residual_clean : assert property (@(posedge i_clk) disable iff (i_reset)
                                      (residual_q >> shamt) == '0);

endmodule

// File: tb/tb_eth_pcs_tx_gearbox.sv
// Bench for eth_pcs_tx_gearbox: a bit-FIFO model feeds a per-cycle scoreboard that a monitor
// drains after every clock edge; directed hand-computed words are checked alongside.
module tb_eth_pcs_tx_gearbox;

  logic        i_clk = 1'b0;
  logic        i_reset = 1'b1;
  logic [1:0]  i_sync_hdr = '0;
  logic [63:0] i_data = '0;
  logic        i_valid = 1'b0;
  logic        o_ready;
  logic [63:0] o_data;
  logic        o_valid;

  int n_checks = 0;
  int n_fail   = 0;
  int n_words  = 0;

  logic [64:0] exp_q[$];
  bit          bq[$];
  int          mseq = 0;
  logic [63:0] last_data = '0;

  always #5 i_clk = ~i_clk;

  eth_pcs_tx_gearbox dut (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_sync_hdr (i_sync_hdr),
    .i_data     (i_data),
    .i_valid    (i_valid),
    .o_ready    (o_ready),
    .o_data     (o_data),
    .o_valid    (o_valid)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock cycle of stimulus; the model decides acceptance and queues the expected output.
  task automatic step(input logic r, input logic v, input logic [65:0] blk, output logic acc);
    logic        er;
    logic [63:0] w;
    @(negedge i_clk);
    i_reset    = r;
    i_valid    = v;
    i_sync_hdr = blk[1:0];
    i_data     = blk[65:2];
    #1;
    er = !r && (mseq != 32);
    chk("o_ready", 64'(o_ready), 64'(er));
    acc = 1'b0;
    w   = '0;
    if (r) begin
      bq.delete();
      mseq      = 0;
      last_data = '0;
      exp_q.push_back({1'b0, 64'h0});
    end else if (mseq == 32) begin
      for (int i = 0; i < 64; i++) w[i] = bq.pop_front();
      mseq      = 0;
      last_data = w;
      exp_q.push_back({1'b1, w});
    end else if (v) begin
      for (int i = 0; i < 66; i++) bq.push_back(blk[i]);
      for (int i = 0; i < 64; i++) w[i] = bq.pop_front();
      mseq++;
      acc       = 1'b1;
      last_data = w;
      exp_q.push_back({1'b1, w});
    end else begin
      exp_q.push_back({1'b0, last_data});
    end
  endtask

  task automatic send_block(input logic [65:0] blk, output int tries);
    logic acc;
    acc   = 1'b0;
    tries = 0;
    while (!acc && tries < 40) begin
      step(1'b0, 1'b1, blk, acc);
      tries++;
    end
    if (!acc) chk("send_timeout", 64'(tries), 64'd0);
  endtask

  task automatic idle(input logic r, input int n);
    logic acc;
    for (int i = 0; i < n; i++) step(r, 1'b0, 66'h0, acc);
  endtask

  initial begin : mon
    logic [64:0] e;
    forever begin
      @(posedge i_clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("o_valid", 64'(o_valid), 64'(e[64]));
        chk("o_data", o_data, e[63:0]);
        if (o_valid) n_words++;
      end
    end
  end

  initial begin : drv
    logic        acc;
    int          tries;
    int          c0;
    logic [31:0] r0, r1, r2;
    logic [65:0] blk;

    // Test 1: reset state and two hand-computed words.
    idle(1'b1, 3);
    @(posedge i_clk); #2;
    chk("t1_rst_valid", 64'(o_valid), 64'd0);
    chk("t1_rst_data", o_data, 64'h0);
    step(1'b0, 1'b1, {64'hFFFF_FFFF_FFFF_FFFF, 2'b01}, acc);
    @(posedge i_clk); #2;
    chk("t1_word0", o_data, 64'hFFFF_FFFF_FFFF_FFFD);
    chk("t1_valid0", 64'(o_valid), 64'd1);
    step(1'b0, 1'b1, {64'h0, 2'b10}, acc);
    @(posedge i_clk); #2;
    chk("t1_word1", o_data, 64'h0000_0000_0000_000B);

    // Test 2: one full frame, data = index, sync alternating.
    idle(1'b1, 2);
    c0 = n_words;
    for (int i = 0; i < 32; i++) begin
      send_block({64'(i), (i % 2 == 0) ? 2'b01 : 2'b10}, tries);
      chk("t2_tries", 64'(tries), 64'd1);
    end
    idle(1'b0, 1);
    @(posedge i_clk); #2;
    chk("t2_words", 64'(n_words - c0), 64'd33);

    // Test 4 and 5: 3-cycle gap after block 5, then block X held through the pause.
    idle(1'b1, 2);
    for (int i = 0; i < 32; i++) begin
      if (i == 5) idle(1'b0, 3);
      send_block({64'h1111_0000_0000_0000 + 64'(i * 7), 2'b10}, tries);
    end
    send_block({64'hDEAD_BEEF_CAFE_F00D, 2'b01}, tries);
    chk("t5_pause_tries", 64'(tries), 64'd2);

    // Test 6: reset after block 17, restart aligned at bit 0.
    idle(1'b1, 2);
    for (int i = 0; i < 17; i++) send_block({64'hA5A5_0000_0000_0000 | 64'(i), 2'b01}, tries);
    idle(1'b1, 1);
    send_block({64'h0123_4567_89AB_CDEF, 2'b10}, tries);
    @(posedge i_clk); #2;
    chk("t6_word0", o_data, 64'h048D_159E_26AF_37BE);
    chk("t6_hdr", 64'(o_data[1:0]), 64'd2);
    for (int i = 0; i < 31; i++) send_block({64'h5A5A_0000_0000_0000 | 64'(i), 2'b10}, tries);
    send_block({64'h7777_7777_7777_7777, 2'b01}, tries);
    chk("t6_pause_tries", 64'(tries), 64'd2);

    // Test 3: continuous random stream of 1000 frames.
    idle(1'b1, 2);
    for (int f = 0; f < 1000; f++) begin
      for (int b = 0; b < 32; b++) begin
        r0  = $urandom;
        r1  = $urandom;
        r2  = $urandom;
        blk = {r0, r1, r2[1:0]};
        send_block(blk, tries);
      end
    end
    idle(1'b0, 2);
    @(posedge i_clk); #2;
    chk("sb_drained", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
